// File: rtl/riscv_mem_responder_pkg.sv
// Shared types for the memory responder: bus widths taken from the core's
// constants header and the packed request payload carried through the queue.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 32
`endif

package riscv_mem_responder_pkg;

    localparam int MEM_ADDR_W = `MEM_ADDR_BITS;
    localparam int MEM_TAG_W  = `MEM_TAG_BITS;
    localparam int MEM_DATA_W = `MEM_DATA_BITS;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_TAG_W-1:0]  tag;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    localparam int MEM_REQ_W = $bits(mem_req_t);

    // A latency of 1 still needs a one-bit counter that only ever holds 0.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/riscv_mem_req_fifo.sv
// Parameterised synchronous FIFO with full/empty flags; pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module riscv_mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end

    // NOTE: sequential state uses non-blocking <= so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Behavioural main memory for the core's memory port: queues tagged requests
// and services them in order against a word array after LATENCY cycles.
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
#(
    parameter int LATENCY        = 4,
    parameter int FIFO_DEPTH     = 2,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic                  mem_req_rw,
    input  logic [MEM_ADDR_W-1:0] mem_req_addr,
    input  logic [MEM_TAG_W-1:0]  mem_req_tag,
    input  logic [MEM_DATA_W-1:0] mem_req_data_bits,
    output logic                  mem_resp_valid,
    output logic [MEM_TAG_W-1:0]  mem_resp_tag,
    output logic [MEM_DATA_W-1:0] mem_resp_data
);

    localparam int CNT_W     = cnt_width(LATENCY);
    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mem_req_t                svc_q, svc_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [MEM_TAG_W-1:0]    resp_tag_q, resp_tag_d;
    logic [MEM_DATA_W-1:0]   resp_data_q, resp_data_d;

    logic [MEM_DATA_W-1:0]   mem_q [MEM_WORDS];
    logic [MEM_WORDS_LOG2-1:0] svc_idx;
    logic                    mem_we;

    mem_req_t                fifo_wdata, fifo_rdata;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                    unused_addr_bits;

    // Ready looks only at occupancy, held low while reset is asserted.
    assign mem_req_ready = reset && !fifo_full;
    assign fifo_push     = mem_req_valid && mem_req_ready;
    assign fifo_wdata    = '{rw: mem_req_rw, addr: mem_req_addr,
                             tag: mem_req_tag, data: mem_req_data_bits};

    riscv_mem_req_fifo #(
        .WIDTH (MEM_REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Upper address bits alias onto the array.
    assign svc_idx          = svc_q.addr[MEM_WORDS_LOG2-1:0];
    assign unused_addr_bits = ^svc_q.addr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        svc_d        = svc_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        fifo_pop     = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    svc_d    = fifo_rdata;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (svc_q.rw) begin
                    mem_we  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_tag_d   = svc_q.tag;
                    resp_data_d  = mem_q[svc_idx];
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            svc_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            svc_q        <= svc_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Array contents survive reset; a write lands only on its final BUSY edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[svc_idx] <= svc_q.data;
    end

    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_tag   = resp_tag_q;
    assign mem_resp_data  = resp_data_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed scenarios plus a
// randomized run against a cycle-level arithmetic model of in-order service.
module tb_riscv_mem_responder;
    import riscv_mem_responder_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 2;
    localparam int WLOG2 = 10;

    typedef struct {
        logic [MEM_TAG_W-1:0]  tag;
        logic [MEM_DATA_W-1:0] data;
        int                    t;
    } resp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  mem_req_valid = 1'b0;
    logic                  mem_req_ready;
    logic                  mem_req_rw = 1'b0;
    logic [MEM_ADDR_W-1:0] mem_req_addr = '0;
    logic [MEM_TAG_W-1:0]  mem_req_tag = '0;
    logic [MEM_DATA_W-1:0] mem_req_data_bits = '0;
    logic                  mem_resp_valid;
    logic [MEM_TAG_W-1:0]  mem_resp_tag;
    logic [MEM_DATA_W-1:0] mem_resp_data;

    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    resp_t resp_log[$];

    riscv_mem_responder #(
        .LATENCY        (LAT),
        .FIFO_DEPTH     (DEPTH),
        .MEM_WORDS_LOG2 (WLOG2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_tag      (mem_resp_tag),
        .mem_resp_data     (mem_resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every response pulse is logged with the edge index it followed.
    always @(negedge clk) begin
        if (mem_resp_valid === 1'b1) resp_log.push_back('{mem_resp_tag, mem_resp_data, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic rw, input logic [MEM_ADDR_W-1:0] addr,
                        input logic [MEM_TAG_W-1:0] tag, input logic [MEM_DATA_W-1:0] data,
                        output int acc, output bit stalled);
        int waited = 0;
        stalled           = 1'b0;
        mem_req_valid     = 1'b1;
        mem_req_rw        = rw;
        mem_req_addr      = addr;
        mem_req_tag       = tag;
        mem_req_data_bits = data;
        while (mem_req_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
            stalled = 1'b1;
        end
        if (mem_req_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, want 1", mem_req_ready, waited);
        end
        acc = cyc + 1;
        tick();
        mem_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset         = 1'b0;
        mem_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data} !== '0)
                $display("FAIL reset_outputs cycle %0d: ready=%b valid=%b tag=%h data=%h, want all 0",
                         i, mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data);
            else n_pass++;
        end
        mem_req_valid = 1'b0;
        reset         = 1'b1;
        tick();
        n_checks++;
        if (mem_req_ready !== 1'b1 || mem_resp_valid !== 1'b0)
            $display("FAIL reset_release: ready=%b valid=%b, want ready=1 valid=0", mem_req_ready, mem_resp_valid);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int acc; bit st;
        resp_log.delete();
        send(1'b1, 'h10, 'd1, 32'hDEADBEEF, acc, st);
        send(1'b0, 'h10, 'd0, '0, acc, st);
        wait_cycles(20);
        n_checks++;
        if (resp_log.size() != 1) $display("FAIL wr_rd_count: got %0d responses, want 1", resp_log.size());
        else n_pass++;
        if (resp_log.size() >= 1) begin
            n_checks++;
            if (resp_log[0].tag !== 'd0 || resp_log[0].data !== 32'hDEADBEEF)
                $display("FAIL wr_rd_data: tag=%h data=%h, want tag=0 data=deadbeef", resp_log[0].tag, resp_log[0].data);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        int acc; bit st;
        resp_log.delete();
        send(1'b0, 'h10, 'd5, '0, acc, st);
        wait_cycles(12);
        n_checks++;
        if (resp_log.size() != 1) $display("FAIL latency_pulses: got %0d, want 1", resp_log.size());
        else n_pass++;
        if (resp_log.size() >= 1) begin
            n_checks++;
            if (resp_log[0].t != acc + LAT + 1 || resp_log[0].tag !== 'd5)
                $display("FAIL latency_cycle: got edge %0d tag %h, want edge %0d tag 05",
                         resp_log[0].t - acc, resp_log[0].tag, LAT + 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [MEM_DATA_W-1:0] bp_data [4];
        int acc; bit st; bit any_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_data[i] = MEM_DATA_W'($urandom);
            send(1'b1, MEM_ADDR_W'('h30 + i), 'd9, bp_data[i], acc, st);
        end
        wait_cycles(15);
        resp_log.delete();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, MEM_ADDR_W'('h30 + i), MEM_TAG_W'(i), '0, acc, st);
            any_stall |= st;
        end
        wait_cycles(40);
        n_checks++;
        if (!any_stall) $display("FAIL bp_ready_drop: ready never dropped, want a stall");
        else n_pass++;
        n_checks++;
        if (resp_log.size() != 4) $display("FAIL bp_count: got %0d responses, want 4", resp_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < resp_log.size(); i++) begin
            n_checks++;
            if (resp_log[i].tag !== MEM_TAG_W'(i) || resp_log[i].data !== bp_data[i])
                $display("FAIL bp_order[%0d]: tag=%h data=%h, want tag=%h data=%h",
                         i, resp_log[i].tag, resp_log[i].data, MEM_TAG_W'(i), bp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_aliasing();
        int acc; bit st;
        resp_log.delete();
        send(1'b1, 'h400, 'd7, 'h55, acc, st);
        send(1'b0, 'h000, 'd8, '0, acc, st);
        wait_cycles(20);
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].tag !== 'd8 || resp_log[0].data !== 'h55)
            $display("FAIL alias: count=%0d tag=%h data=%h, want 1 response tag=08 data=55",
                     resp_log.size(), (resp_log.size() > 0) ? resp_log[0].tag : '0,
                     (resp_log.size() > 0) ? resp_log[0].data : '0);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int acc; bit st;
        send(1'b1, 'h20, 'd9, 32'hA5A5_0001, acc, st);
        wait_cycles(10);
        resp_log.delete();
        send(1'b0, 'h20, 'd2, '0, acc, st);
        send(1'b1, 'h20, 'd10, 32'h0BAD_0BAD, acc, st);
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data} !== '0)
            $display("FAIL midflight_async: ready=%b valid=%b tag=%h data=%h, want all 0",
                     mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data);
        else n_pass++;
        tick();
        reset = 1'b1;
        wait_cycles(20);
        n_checks++;
        if (resp_log.size() != 0) $display("FAIL midflight_discard: got %0d responses, want 0", resp_log.size());
        else n_pass++;
        send(1'b0, 'h20, 'd3, '0, acc, st);
        wait_cycles(20);
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].tag !== 'd3 || resp_log[0].data !== 32'hA5A5_0001)
            $display("FAIL midflight_contents: count=%0d data=%h, want 1 response tag=03 data=a5a50001",
                     resp_log.size(), (resp_log.size() > 0) ? resp_log[0].data : '0);
        else n_pass++;
    endtask

    task automatic test_random();
        resp_t                 exp_q[$];
        int                    pend_p[$];
        logic [MEM_DATA_W-1:0] mmem [int];
        int  next_free = 0;
        int  steps = 0;
        int  idx = 0;
        int  a, p;
        bit  hold = 1'b0;
        logic [MEM_ADDR_W-1:0] addr;
        while (steps < 300 || (exp_q.size() != 0 && steps < 800)) begin
            while (pend_p.size() != 0 && pend_p[0] <= cyc) void'(pend_p.pop_front());
            n_checks++;
            if (mem_req_ready !== (pend_p.size() < DEPTH))
                $display("FAIL rand_ready @%0d: got %b, want %b", cyc, mem_req_ready, pend_p.size() < DEPTH);
            else n_pass++;
            if (exp_q.size() != 0 && exp_q[0].t == cyc) begin
                n_checks++;
                if ({mem_resp_valid, mem_resp_tag, mem_resp_data} !== {1'b1, exp_q[0].tag, exp_q[0].data})
                    $display("FAIL rand_resp @%0d: valid=%b tag=%h data=%h, want valid=1 tag=%h data=%h",
                             cyc, mem_resp_valid, mem_resp_tag, mem_resp_data, exp_q[0].tag, exp_q[0].data);
                else n_pass++;
                void'(exp_q.pop_front());
            end else begin
                n_checks++;
                if (mem_resp_valid !== 1'b0) $display("FAIL rand_idle @%0d: valid=%b, want 0", cyc, mem_resp_valid);
                else n_pass++;
            end
            if (!hold) begin
                if (steps < 300 && $urandom_range(0, 9) < 6) begin
                    idx  = 'h100 + 3 * int'($urandom_range(0, 7));
                    addr = MEM_ADDR_W'($urandom);
                    addr[WLOG2-1:0] = idx[WLOG2-1:0];
                    mem_req_rw = ($urandom_range(0, 2) == 0);
                    if (!mem_req_rw && !mmem.exists(idx)) mem_req_rw = 1'b1;
                    mem_req_addr      = addr;
                    mem_req_tag       = MEM_TAG_W'($urandom);
                    mem_req_data_bits = MEM_DATA_W'($urandom);
                    mem_req_valid     = 1'b1;
                end else begin
                    mem_req_valid = 1'b0;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                a = cyc + 1;
                p = (a + 1 > next_free) ? a + 1 : next_free;
                if (mem_req_rw) begin
                    mmem[idx] = mem_req_data_bits;
                    next_free = p + LAT + 1;
                end else begin
                    exp_q.push_back('{mem_req_tag, mmem[idx], p + LAT});
                    next_free = p + LAT + 2;
                end
                pend_p.push_back(p);
                hold = 1'b0;
            end else begin
                hold = mem_req_valid;
            end
            tick();
            steps++;
        end
        mem_req_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rand_drain: %0d responses missing, want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_backpressure();
        test_aliasing();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
